// File: rtl/ppu_cpu_reg_port.sv
// ppu_cpu_reg_port: CPU-side PPU register decode, scroll/VRAM address state and $2007 VRAM handshake
module ppu_cpu_reg_port #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        cpu_reg_sel,
   input  logic              cpu_wr_en,
   input  logic              cpu_rd_en,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_busy,
   input  logic              vblank_in,
   output logic              vblank_clr,
   output logic [7:0]        ppu_ctrl1,
   output logic [7:0]        ppu_ctrl2,
   output logic [15:0]       cpu_scroll_addr,
   output logic              vram_req,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   input  logic              vram_ack,
   input  logic [7:0]        vram_rdata
);
   typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;
   state_t state, state_nx;
   logic toggle;
   logic [5:0] temp_hi;
   logic [7:0] rbuf;
   logic [ADDR_W-1:0] vaddr, vaddr_sel, inc;
   logic rd, idle, done, sel7, start;
   assign rd = cpu_rd_en & ~cpu_wr_en;
   assign idle = state == IDLE;
   assign done = !idle && vram_ack;
   assign sel7 = cpu_reg_sel == 3'd7;
   assign start = idle && sel7 && (cpu_wr_en || cpu_rd_en);
   assign inc = ppu_ctrl1[2] ? ADDR_W'(32) : ADDR_W'(1);
   // a $2006 low-byte write lands before the completing access's increment
   assign vaddr_sel = (cpu_wr_en && cpu_reg_sel == 3'd6 && toggle) ? ADDR_W'({temp_hi, cpu_wdata}) : vaddr;
   assign cpu_busy = !idle;
   assign vram_req = !idle;
   assign vram_we = state == WR_REQ;
   always_comb begin
      state_nx = done ? IDLE : (idle && sel7 && cpu_wr_en) ? WR_REQ : (idle && sel7 && rd) ? RD_REQ : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata <= '0;
         vblank_clr <= 1'b0;
         ppu_ctrl1 <= '0;
         ppu_ctrl2 <= '0;
         cpu_scroll_addr <= '0;
         vram_addr <= '0;
         vram_wdata <= '0;
         toggle <= 1'b0;
         temp_hi <= '0;
         vaddr <= '0;
         rbuf <= '0;
      end else begin
         vaddr <= done ? vaddr_sel + inc : vaddr_sel;
         if (cpu_wr_en) begin
            case (cpu_reg_sel)
               3'd0: ppu_ctrl1 <= cpu_wdata;
               3'd1: ppu_ctrl2 <= cpu_wdata;
               3'd5: begin
                  if (toggle) cpu_scroll_addr[15:8] <= cpu_wdata;
                  else cpu_scroll_addr[7:0] <= cpu_wdata;
                  toggle <= ~toggle;
               end
               3'd6: begin
                  if (!toggle) temp_hi <= cpu_wdata[5:0];
                  toggle <= ~toggle;
               end
               default: ;
            endcase
         end
         if (rd) begin
            cpu_rdata <= (cpu_reg_sel == 3'd2) ? {vblank_in, 7'b0} : sel7 ? rbuf : 8'h00;
            if (cpu_reg_sel == 3'd2) toggle <= 1'b0;
         end
         vblank_clr <= rd && cpu_reg_sel == 3'd2;
         if (start) vram_addr <= vaddr;
         if (start && cpu_wr_en) vram_wdata <= cpu_wdata;
         if (state == RD_REQ && vram_ack) rbuf <= vram_rdata;
      end
   end
endmodule

// File: tb/tb_ppu_cpu_reg_port.sv
// tb_ppu_cpu_reg_port: randomized directed bench for ppu_cpu_reg_port against a register-level model
module tb_ppu_cpu_reg_port;
   localparam int AW = 14;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [2:0] cpu_reg_sel = '0;
   logic cpu_wr_en = 1'b0, cpu_rd_en = 1'b0, vblank_in = 1'b0, vram_ack = 1'b0;
   logic [7:0] cpu_wdata = '0, vram_rdata = '0;
   logic [7:0] cpu_rdata, ppu_ctrl1, ppu_ctrl2, vram_wdata;
   logic cpu_busy, vblank_clr, vram_req, vram_we;
   logic [15:0] cpu_scroll_addr;
   logic [AW-1:0] vram_addr;
   int tests = 0, fails = 0;
   logic [7:0] m_c1, m_c2, m_buf, m_rd;
   logic [15:0] m_scr;
   logic m_tog;
   logic [5:0] m_tmp;
   logic [AW-1:0] m_va;

   ppu_cpu_reg_port #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_reg_sel(cpu_reg_sel), .cpu_wr_en(cpu_wr_en),
      .cpu_rd_en(cpu_rd_en), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
      .vblank_in(vblank_in), .vblank_clr(vblank_clr), .ppu_ctrl1(ppu_ctrl1), .ppu_ctrl2(ppu_ctrl2),
      .cpu_scroll_addr(cpu_scroll_addr), .vram_req(vram_req), .vram_we(vram_we),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_c1 = 0; m_c2 = 0; m_buf = 0; m_rd = 0; m_scr = 0; m_tog = 0; m_tmp = 0; m_va = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdata"}, cpu_rdata, 0);
      chk({tag, "_ctrl"}, {ppu_ctrl1, ppu_ctrl2}, 0);
      chk({tag, "_scroll"}, cpu_scroll_addr, 0);
      chk({tag, "_vram"}, {vram_req, vram_we, cpu_busy, vblank_clr}, 0);
      chk({tag, "_vaddr"}, vram_addr, 0);
      chk({tag, "_vwdata"}, vram_wdata, 0);
   endtask

   // register-level effect of a CPU write to $2000-$2006
   task automatic model_write(input logic [2:0] s, input logic [7:0] d);
      if (s == 0) m_c1 = d;
      if (s == 1) m_c2 = d;
      if (s == 5) begin
         if (m_tog) m_scr[15:8] = d; else m_scr[7:0] = d;
         m_tog = !m_tog;
      end
      if (s == 6) begin
         if (m_tog) m_va = {m_tmp, d}; else m_tmp = d[5:0];
         m_tog = !m_tog;
      end
   endtask

   task automatic wr(input logic [2:0] s, input logic [7:0] d);
      cpu_reg_sel = s; cpu_wdata = d; cpu_wr_en = 1;
      tick();
      cpu_wr_en = 0;
      model_write(s, d);
      chk("wr_ctrl1", ppu_ctrl1, m_c1);
      chk("wr_ctrl2", ppu_ctrl2, m_c2);
      chk("wr_scroll", cpu_scroll_addr, m_scr);
   endtask

   task automatic rd(input logic [2:0] s);
      logic vb;
      vb = 1'($urandom);
      cpu_reg_sel = s; vblank_in = vb; cpu_rd_en = 1;
      tick();
      cpu_rd_en = 0;
      m_rd = (s == 2) ? {vb, 7'b0} : 8'h00;
      if (s == 2) m_tog = 0;
      chk("rd_data", cpu_rdata, m_rd);
      chk("rd_vbclr", vblank_clr, s == 2);
      if (s == 2) begin
         tick();
         chk("vbclr_pulse", vblank_clr, 0);
      end
   endtask

   task automatic setva(input logic [AW-1:0] a);
      rd(2);
      wr(6, {2'b00, a[13:8]});
      wr(6, a[7:0]);
   endtask

   task automatic strobe7(input logic w, input logic [7:0] d);
      cpu_reg_sel = 7; cpu_wdata = d;
      if (w) cpu_wr_en = 1; else cpu_rd_en = 1;
      tick();
      cpu_wr_en = 0; cpu_rd_en = 0;
   endtask

   task automatic finish_acc(input logic w, input logic [7:0] rv);
      m_va = m_va + (m_c1[2] ? AW'(32) : AW'(1));
      if (!w) m_buf = rv;
   endtask

   // one complete $2007 access; ack rises on the n-th cycle of the request
   task automatic acc(input logic w, input int n);
      logic [7:0] d, rv;
      logic [AW-1:0] a;
      d = 8'($urandom); rv = 8'($urandom); a = m_va;
      strobe7(w, d);
      if (!w) begin
         m_rd = m_buf;
         chk("rd7_data", cpu_rdata, m_rd);
      end
      for (int i = 0; i < n; i++) begin
         chk("acc_req", {vram_req, cpu_busy}, 2'b11);
         chk("acc_we", vram_we, w);
         chk("acc_addr", vram_addr, a);
         if (w) chk("acc_wdata", vram_wdata, d);
         vram_ack = (i == n - 1); vram_rdata = rv;
         tick();
      end
      vram_ack = 0;
      chk("acc_done", {vram_req, cpu_busy}, 0);
      finish_acc(w, rv);
   endtask

   initial begin
      logic [7:0] d1, d2, rv;
      logic [AW-1:0] a0;
      model_reset();
      tick(); tick();
      chk_zero("reset");
      rst_n = 1;
      tick();
      wr(5, 8'h12); wr(5, 8'h34);
      chk("scroll_3412", cpu_scroll_addr, 16'h3412);
      wr(5, 8'h55);
      vblank_in = 1; cpu_reg_sel = 2; cpu_rd_en = 1;
      tick();
      cpu_rd_en = 0; m_tog = 0;
      chk("rd2_vb", cpu_rdata, 8'h80);
      chk("vbclr_hi", vblank_clr, 1);
      tick();
      chk("vbclr_lo", vblank_clr, 0);
      wr(5, 8'h66);
      chk("scroll_66", cpu_scroll_addr[7:0], 8'h66);
      m_rd = 8'h80;
      cpu_reg_sel = 0; cpu_wdata = 8'h00; cpu_wr_en = 1; cpu_rd_en = 1;
      tick();
      cpu_wr_en = 0; cpu_rd_en = 0; m_c1 = 8'h00;
      chk("wr_rd_hold", cpu_rdata, m_rd);
      chk("wr_rd_ctrl1", ppu_ctrl1, m_c1);
      setva(14'h2108);
      acc(1, 3);
      acc(1, 1);
      wr(0, 8'h04);
      setva(14'h2000);
      acc(1, 2); acc(1, 1); acc(0, 1);
      wr(0, 8'h00);
      setva(14'h2400);
      acc(0, 2); acc(0, 3);
      setva(14'h3FFF);
      acc(1, 1); acc(1, 1);
      wr(0, 8'h04);
      setva(14'h3FF0);
      acc(1, 1); acc(0, 1);
      // accesses arriving while busy are dropped
      d1 = 8'($urandom); d2 = ~d1; rv = 8'($urandom); a0 = m_va;
      strobe7(1, d1);
      strobe7(1, d2);
      chk("drop_wdata", vram_wdata, d1);
      strobe7(0, 8'h00);
      m_rd = m_buf;
      chk("drop_rd", cpu_rdata, m_rd);
      chk("drop_we", vram_we, 1);
      vram_ack = 1; vram_rdata = rv;
      tick();
      vram_ack = 0;
      finish_acc(1, rv);
      for (int i = 0; i < 3; i++) begin
         chk("drop_one_txn", vram_req, 0);
         tick();
      end
      acc(0, 1);
      acc(0, 1);
      // $2006 while busy retargets vaddr but not the in-flight access
      a0 = m_va;
      strobe7(1, 8'hC3);
      rd(2);
      wr(6, 8'h15);
      wr(6, 8'h40);
      chk("busy6_addr", vram_addr, a0);
      chk("busy6_req", vram_req, 1);
      vram_ack = 1;
      tick();
      vram_ack = 0;
      finish_acc(1, 8'h00);
      acc(1, 1);
      for (int k = 0; k < 30; k++) begin
         int r;
         r = $urandom_range(0, 3);
         if (r == 0) wr(3'($urandom_range(0, 6)), 8'($urandom));
         else if (r == 1) rd(3'($urandom_range(0, 6)));
         else acc(1'($urandom), $urandom_range(1, 4));
      end
      wr(5, 8'hA5);
      strobe7(1, 8'h77);
      chk("rst_mid_req", vram_req, 1);
      rst_n = 0;
      #1;
      chk_zero("rst_mid");
      tick();
      rst_n = 1;
      model_reset();
      tick();
      chk_zero("post_rst");
      acc(1, 2);
      acc(0, 1);
      acc(0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
